// File: rtl/oai222_bist_pkg.sv
// rtl/oai222_bist_pkg.sv - shared types, constants and reference function for the OAI222 BIST sequencer
package oai222_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_WAIT,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   localparam int         NUM_VEC  = 64;
   localparam logic [5:0] LAST_VEC = 6'(NUM_VEC - 1);

   // v = {C2,C1,B2,B1,A2,A1}
   function automatic logic expected_zn(logic [5:0] v);
      return ~((v[0] | v[1]) & (v[2] | v[3]) & (v[4] | v[5]));
   endfunction

endpackage

// File: rtl/oai222_bist_settle_cnt.sv
// rtl/oai222_bist_settle_cnt.sv - 8-bit loadable down-counter; last flags a count of one
module oai222_bist_settle_cnt (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       dec,
   output logic       last
);

   logic [7:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != 8'd0)) begin
         count <= count - 8'd1;
      end
   end

   assign last = (count == 8'd1);

endmodule

// File: rtl/oai222_bist_ctrl.sv
// rtl/oai222_bist_ctrl.sv - OAI222 BIST sequencer: applies 64 vectors, checks ZN, counts errors
// OAI222_BIST_FAIL_CAPTURE_EN adds the FAIL_VEC port holding the first failing vector of a run.
module oai222_bist_ctrl
   import oai222_bist_pkg::*;
#(
   parameter int SETTLE_CYC = 2,
   parameter int ERR_W      = 7
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   output logic             A1,
   output logic             A2,
   output logic             B1,
   output logic             B2,
   output logic             C1,
   output logic             C2,
   input  logic             ZN,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [ERR_W-1:0] ERR_CNT
`ifdef OAI222_BIST_FAIL_CAPTURE_EN
   ,
   output logic [5:0]       FAIL_VEC
`endif
);

   if ((SETTLE_CYC < 1) || (SETTLE_CYC > 255)) begin : g_bad_settle
      $error("oai222_bist_ctrl: SETTLE_CYC must be within 1..255");
   end

   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   state_t           state;
   state_t           state_nxt;
   logic [5:0]       vec;
   logic [5:0]       pins;
   logic [ERR_W-1:0] err_cnt;
   logic             start_run;
   logic             apply_vec;
   logic             cnt_dec;
   logic             sample;
   logic             settle_last;
   logic             mismatch;

   oai222_bist_settle_cnt u_settle (
      .clk      (CLK),
      .rst      (RST),
      .load     (apply_vec),
      .load_val (8'(SETTLE_CYC)),
      .dec      (cnt_dec),
      .last     (settle_last)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // START is only looked at in IDLE and DONE, so requests during a run are dropped.
   always_comb begin
      state_nxt = state;
      start_run = 1'b0;
      apply_vec = 1'b0;
      cnt_dec   = 1'b0;
      sample    = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (START) begin
               start_run = 1'b1;
               state_nxt = ST_APPLY;
            end
         end
         ST_APPLY: begin
            apply_vec = 1'b1;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_dec = 1'b1;
            if (settle_last) begin
               state_nxt = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            sample    = 1'b1;
            state_nxt = (vec == LAST_VEC) ? ST_DONE : ST_APPLY;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign mismatch = sample && (ZN != expected_zn(vec));

   always_ff @(posedge CLK) begin
      if (RST) begin
         vec     <= '0;
         pins    <= '0;
         err_cnt <= '0;
      end else begin
         if (start_run) begin
            vec     <= '0;
            err_cnt <= '0;
         end else begin
            if (sample && (vec != LAST_VEC)) begin
               vec <= vec + 6'd1;
            end
            if (mismatch && (err_cnt != ERR_MAX)) begin
               err_cnt <= err_cnt + 1'b1;
            end
         end
         if (apply_vec) begin
            pins <= vec;
         end
      end
   end

`ifdef OAI222_BIST_FAIL_CAPTURE_EN
   logic [5:0] fail_vec;
   logic       fail_seen;

   // fail_seen is needed because vector 0 can itself be the first failure.
   always_ff @(posedge CLK) begin
      if (RST || start_run) begin
         fail_vec  <= '0;
         fail_seen <= 1'b0;
      end else if (mismatch && !fail_seen) begin
         fail_vec  <= vec;
         fail_seen <= 1'b1;
      end
   end

   assign FAIL_VEC = fail_vec;
`endif

   assign {C2, C1, B2, B1, A2, A1} = pins;
   assign BUSY    = (state == ST_APPLY) || (state == ST_WAIT) || (state == ST_SAMPLE);
   assign DONE    = (state == ST_DONE);
   assign PASS    = DONE && (err_cnt == '0);
   assign ERR_CNT = err_cnt;

endmodule

// File: tb/tb_oai222_bist_ctrl.sv
// tb/tb_oai222_bist_ctrl.sv - randomized self-checking bench for oai222_bist_ctrl
// Builds with or without OAI222_BIST_FAIL_CAPTURE_EN; a second instance uses ERR_W=4.
module tb_oai222_bist_ctrl;

   localparam int S       = 2;
   localparam int RUN_CYC = 64 * (S + 2);

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  zn_mode;
   logic [63:0] flip;

   logic        a1, a2, b1, b2, c1, c2, zn, busy, done, pass;
   logic [6:0]  err_cnt;
   logic        s_a1, s_a2, s_b1, s_b2, s_c1, s_c2, s_zn, s_busy, s_done, s_pass;
   logic [3:0]  s_err_cnt;
   logic [5:0]  pins;
   logic [5:0]  s_pins;
`ifdef OAI222_BIST_FAIL_CAPTURE_EN
   logic [5:0]  fail_vec;
   logic [5:0]  s_fail_vec;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // OAI222 truth from the pair rule: ZN is 0 only when every pair has a 1.
   function automatic logic golden_zn(logic [5:0] v);
      return !((v[1:0] != 2'b00) && (v[3:2] != 2'b00) && (v[5:4] != 2'b00));
   endfunction

   // Cell under test: 0 healthy (with optional flipped vectors), 1 stuck-at-0, 2 stuck-at-1.
   function automatic logic cell_zn(logic [5:0] v, logic [1:0] mode, logic [63:0] fl);
      if (mode == 2'd1) return 1'b0;
      if (mode == 2'd2) return 1'b1;
      return golden_zn(v) ^ fl[v];
   endfunction

   assign pins   = {c2, c1, b2, b1, a2, a1};
   assign s_pins = {s_c2, s_c1, s_b2, s_b1, s_a2, s_a1};
   assign zn     = cell_zn(pins, zn_mode, flip);
   assign s_zn   = cell_zn(s_pins, zn_mode, flip);

   oai222_bist_ctrl #(.SETTLE_CYC(S), .ERR_W(7)) dut (
      .CLK(clk), .RST(rst), .START(start),
      .A1(a1), .A2(a2), .B1(b1), .B2(b2), .C1(c1), .C2(c2),
      .ZN(zn), .BUSY(busy), .DONE(done), .PASS(pass), .ERR_CNT(err_cnt)
`ifdef OAI222_BIST_FAIL_CAPTURE_EN
      , .FAIL_VEC(fail_vec)
`endif
   );

   oai222_bist_ctrl #(.SETTLE_CYC(S), .ERR_W(4)) dut_small (
      .CLK(clk), .RST(rst), .START(start),
      .A1(s_a1), .A2(s_a2), .B1(s_b1), .B2(s_b2), .C1(s_c1), .C2(s_c2),
      .ZN(s_zn), .BUSY(s_busy), .DONE(s_done), .PASS(s_pass), .ERR_CNT(s_err_cnt)
`ifdef OAI222_BIST_FAIL_CAPTURE_EN
      , .FAIL_VEC(s_fail_vec)
`endif
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic ref_model(output int cnt, output int first);
      cnt   = 0;
      first = 0;
      for (int v = 0; v < 64; v++) begin
         if (cell_zn(6'(v), zn_mode, flip) != golden_zn(6'(v))) begin
            if (cnt == 0) first = v;
            cnt++;
         end
      end
   endtask

   // Pulses START, then follows the run cycle by cycle; glitch_c > 0 re-pulses START mid-run.
   task automatic run_test(input string tag, input int glitch_c);
      int pin_bad = 0;
      int flag_bad = 0;
      int small_bad = 0;
      int exp_cnt, exp_first, exp_small;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= RUN_CYC; c++) begin
         if (c == glitch_c) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         if (int'(pins) != (c - 1) / (S + 2)) pin_bad++;
         if (c < RUN_CYC) begin
            if (!busy || done) flag_bad++;
         end else if (busy || !done) begin
            flag_bad++;
         end
         if ((s_done != done) || (s_busy != busy) || (s_pins != pins)) small_bad++;
      end
      ref_model(exp_cnt, exp_first);
      exp_small = (exp_cnt > 15) ? 15 : exp_cnt;
      check({tag, "_pin_seq"}, pin_bad, 0);
      check({tag, "_busy_done_timing"}, flag_bad, 0);
      check({tag, "_small_inst_timing"}, small_bad, 0);
      check({tag, "_err_cnt"}, int'(err_cnt), exp_cnt);
      check({tag, "_pass"}, int'(pass), (exp_cnt == 0) ? 1 : 0);
      check({tag, "_small_err_cnt"}, int'(s_err_cnt), exp_small);
      check({tag, "_small_pass"}, int'(s_pass), (exp_cnt == 0) ? 1 : 0);
`ifdef OAI222_BIST_FAIL_CAPTURE_EN
      check({tag, "_fail_vec"}, int'(fail_vec), exp_first);
`endif
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_done_hold"}, int'(done && !busy), 1);
      check({tag, "_pins_hold"}, int'(pins), 63);
   endtask

   initial begin
      int seen10;
      rst     = 1'b1;
      start   = 1'b0;
      zn_mode = 2'd0;
      flip    = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_pass", int'(pass), 0);
      check("reset_err", int'(err_cnt), 0);
      check("reset_pins", int'(pins), 0);
`ifdef OAI222_BIST_FAIL_CAPTURE_EN
      check("reset_fail_vec", int'(fail_vec), 0);
`endif
      repeat (4) @(posedge clk);
      #1;
      check("idle_no_start", int'(busy | done), 0);

      zn_mode = 2'd0;
      run_test("golden", 0);
      zn_mode = 2'd1;
      run_test("stuck0", 0);
      zn_mode = 2'd2;
      run_test("stuck1", 0);
      zn_mode = 2'd0;
      run_test("start_while_busy", 5 * (S + 2) + 2);

      // Reset in the middle of a failing run, once vector 10 is on the pins.
      zn_mode = 2'd1;
      start   = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      seen10 = 0;
      for (int c = 0; c < RUN_CYC && seen10 == 0; c++) begin
         @(posedge clk); #1;
         if (pins == 6'd10) seen10 = 1;
      end
      check("reach_vec10", seen10, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_pins", int'(pins), 0);
      check("midrst_err", int'(err_cnt), 0);
      check("midrst_small_err", int'(s_err_cnt), 0);
      repeat (3) @(posedge clk);
      #1;
      check("midrst_stays_idle", int'(busy | done), 0);
      run_test("after_rst", 0);

      for (int r = 0; r < 6; r++) begin
         zn_mode = 2'd0;
         case (r % 3)
            0: flip = 64'd1 << $urandom_range(63);
            1: flip = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            default: flip = {$urandom, $urandom};
         endcase
         run_test($sformatf("rand%0d", r), (r == 2) ? $urandom_range(RUN_CYC - 2, 1) : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
